// File: rtl/cdc_hs_src_ctrl.sv
// Source-side sequencer for a 4-phase req/ack clock-domain-crossing handshake.
// Captures one upstream word, holds it stable on xfer_data_o, raises xfer_req_o
// after a setup delay, then waits for the synchronized ack to rise and fall.
//
// Ports:
//   clk_i            clock
//   rstn_i           synchronous active-low reset
//   src_valid_i      upstream word valid
//   src_data_i       upstream word
//   src_ready_o      block can accept a word (combinational)
//   xfer_data_o      registered word presented to the destination synchronizer
//   xfer_req_o       registered request to the destination
//   xfer_ack_sync_i  destination ack, already synchronized into clk_i
//   done_o           one-cycle pulse when a transfer completes
//   err_o            sticky timeout error
//   err_clr_i        clears err_o (only honoured in ERR with ack low)
//   xfer_cnt_o       completed-transfer count, wraps
module cdc_hs_src_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             src_ready_o,
    output logic [WIDTH-1:0] xfer_data_o,
    output logic             xfer_req_o,
    input  logic             xfer_ack_sync_i,
    output logic             done_o,
    output logic             err_o,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    localparam int unsigned SETUP_W    = 4;
    localparam int unsigned WAIT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WAIT_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [SETUP_W-1:0] setup_cnt_q;
    logic [SETUP_W-1:0] setup_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_d;
    logic [WIDTH-1:0]   data_d;
    logic               req_d;
    logic               done_d;
    logic               err_d;
    logic [CNT_W-1:0]   cnt_d;

    logic               accept_c;
    logic               setup_done_c;
    logic               timeout_c;

    // A stale-high ack (previous transfer not yet released) blocks acceptance.
    assign src_ready_o  = (state_q == ST_IDLE) && !err_o && !xfer_ack_sync_i && rstn_i;
    assign accept_c     = src_valid_i && src_ready_o;
    assign setup_done_c = (setup_cnt_q == SETUP_W'(SETUP_CYC - 1));
    // An ack edge on the timeout cycle takes priority (checked first below).
    assign timeout_c    = TIMEOUT_EN && (wait_cnt_q == WAIT_W'(WAIT_LAST));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (setup_done_c) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (xfer_ack_sync_i)  state_d = ST_RELEASE;
                else if (timeout_c)   state_d = ST_ERR;
            end
            ST_RELEASE: begin
                if (!xfer_ack_sync_i) state_d = ST_IDLE;
                else if (timeout_c)   state_d = ST_ERR;
            end
            ST_ERR: begin
                if (err_clr_i && !xfer_ack_sync_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; req and err follow the state being entered.
    always_comb begin
        data_d      = xfer_data_o;
        req_d       = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = xfer_cnt_o;
        setup_cnt_d = '0;
        wait_cnt_d  = '0;

        if (accept_c) data_d = src_data_i;

        req_d  = (state_d == ST_REQ);
        err_d  = (state_d == ST_ERR);
        done_d = (state_q == ST_RELEASE) && (state_d == ST_IDLE);

        if (done_d) cnt_d = xfer_cnt_o + CNT_W'(1);

        if (state_q == ST_SETUP) setup_cnt_d = setup_cnt_q + SETUP_W'(1);

        // Wait counter restarts on every entry into REQ or RELEASE.
        if (TIMEOUT_EN && (state_q == ST_REQ || state_q == ST_RELEASE) && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Registered outputs and counters.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            xfer_data_o <= '0;
            xfer_req_o  <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            xfer_cnt_o  <= '0;
            setup_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            xfer_data_o <= data_d;
            xfer_req_o  <= req_d;
            done_o      <= done_d;
            err_o       <= err_d;
            xfer_cnt_o  <= cnt_d;
            setup_cnt_q <= setup_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Self-checking bench for cdc_hs_src_ctrl (WIDTH=8, SETUP_CYC=2, TIMEOUT=8, CNT_W=2).
module tb_cdc_hs_src_ctrl;

    localparam int SETUP = 2;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic [7:0] xfer_data;
    logic       xfer_req;
    logic       ack;
    logic       done;
    logic       err;
    logic       err_clr;
    logic [1:0] xfer_cnt;

    cdc_hs_src_ctrl #(
        .WIDTH(8), .SETUP_CYC(2), .TIMEOUT(8), .CNT_W(2)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .src_valid_i    (src_valid),
        .src_data_i     (src_data),
        .src_ready_o    (src_ready),
        .xfer_data_o    (xfer_data),
        .xfer_req_o     (xfer_req),
        .xfer_ack_sync_i(ack),
        .done_o         (done),
        .err_o          (err),
        .err_clr_i      (err_clr),
        .xfer_cnt_o     (xfer_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         model_cnt = 0;
    logic [7:0] last_data = 8'h00;

    logic [13:0] act;
    assign act = {src_ready, xfer_req, done, err, xfer_cnt, xfer_data};

    typedef struct {
        logic [7:0] data;
        int         d1;
        int         d2;
        bit         exp_err;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t       tbl [8];
    logic [1:0] wrap_exp [5];

    function automatic logic [13:0] pk(bit rdy, bit rq, bit dn, bit er, logic [1:0] c, logic [7:0] d);
        return {rdy, rq, dn, er, c, d};
    endfunction

    task automatic chk(input string nm, input logic [13:0] a, input logic [13:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got rdy=%b req=%b done=%b err=%b cnt=%0d data=%02h, want rdy=%b req=%b done=%b err=%b cnt=%0d data=%02h",
                     nm, $time, a[13], a[12], a[11], a[10], a[9:8], a[7:0],
                     e[13], e[12], e[11], e[10], e[9:8], e[7:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer whose expected timeline is derived from the handshake rules:
    // req rises SETUP edges after accept, ack is sampled high d1 edges later,
    // low d2 edges after that; a wait longer than TO edges raises the error.
    task automatic run_xfer(input logic [7:0] d, input int d1, input int d2, output bit saw_err);
        int  r, f, e, c, dn, idle_at, last, ack_end;
        bit  to1, to2, ep, x_req, x_done, x_err, x_rdy;
        r       = SETUP;
        to1     = d1 > TO;
        f       = r + d1;
        to2     = !to1 && (d2 > TO);
        ep      = to1 || to2;
        e       = to1 ? r + TO : f + TO;
        c       = to1 ? e + 1 : e + 2;
        dn      = f + d2;
        idle_at = ep ? c : dn;
        last    = ep ? c : dn + 1;
        ack_end = to2 ? c : dn;
        saw_err = 1'b0;

        src_valid = 1'b1;
        src_data  = d;
        ack       = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk_int("xfer_ready_pre", int'(src_ready), 1);
        for (int k = 0; k <= last; k++) begin
            step();
            x_req  = (k >= r) && (k < (to1 ? e : f));
            x_done = !ep && (k == dn);
            x_err  = ep && (k >= e) && (k < c);
            x_rdy  = (k >= idle_at);
            if (x_done) model_cnt = (model_cnt + 1) % 4;
            chk("xfer_cycle", act, pk(x_rdy, x_req, x_done, x_err, 2'(model_cnt), d));
            if (err) saw_err = 1'b1;
            src_valid = 1'b0;
            ack       = !to1 && (k + 1 >= f) && (k + 1 < ack_end);
            err_clr   = ep && (k + 1 >= e + 1) && (k + 1 <= c);
        end
        ack       = 1'b0;
        err_clr   = 1'b0;
        last_data = d;
    endtask

    // Completes the transfer in flight with an ack that mirrors req.
    task automatic drain(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (done) got = 1'b1;
            ack = xfer_req;
        end
        ack = 1'b0;
        chk_int(nm, int'(got), 1);
        model_cnt = (model_cnt + 1) % 4;
        chk_int("drain_cnt", int'(xfer_cnt), model_cnt);
    endtask

    initial begin
        bit         se;
        int         dones, acc, gap;
        bit         prev_done, a1, a2;
        logic [7:0] prev;

        tbl[0] = '{8'hA5, 3, 3, 1'b0, 2'd1};
        tbl[1] = '{8'h3C, 1, 1, 1'b0, 2'd2};
        tbl[2] = '{8'h5A, 8, 1, 1'b0, 2'd3};
        tbl[3] = '{8'h0F, 9, 2, 1'b1, 2'd3};
        tbl[4] = '{8'hF0, 2, 8, 1'b0, 2'd0};
        tbl[5] = '{8'h11, 2, 9, 1'b1, 2'd0};
        tbl[6] = '{8'h22, 1, 8, 1'b0, 2'd1};
        tbl[7] = '{8'h96, 8, 8, 1'b0, 2'd2};
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        // Reset with a valid word pending: nothing accepted, all outputs low.
        rstn = 1'b0; src_valid = 1'b1; src_data = 8'hFF; ack = 1'b0; err_clr = 1'b0;
        step();
        step();
        chk("reset", act, pk(0, 0, 0, 0, 2'd0, 8'h00));
        rstn = 1'b1;
        src_valid = 1'b0;
        step();
        chk("post_reset", act, pk(1, 0, 0, 0, 2'd0, 8'h00));

        // Directed vectors: normal, boundary (ack on timeout cycle) and timeouts.
        for (int i = 0; i < 8; i++) begin
            run_xfer(tbl[i].data, tbl[i].d1, tbl[i].d2, se);
            chk_int("tbl_err", int'(se), int'(tbl[i].exp_err));
            chk_int("tbl_cnt", int'(xfer_cnt), int'(tbl[i].exp_cnt));
        end

        // err_clr outside ERR has no effect.
        err_clr = 1'b1;
        step();
        chk("clr_idle", act, pk(1, 0, 0, 0, 2'(model_cnt), last_data));
        err_clr = 1'b0;

        // Back-to-back words with valid held high.
        src_valid = 1'b1; src_data = 8'h01;
        prev = xfer_data; prev_done = 1'b0;
        dones = 0; acc = 0; a1 = 1'b0; a2 = 1'b0;
        for (int i = 0; i < 200 && dones < 3; i++) begin
            step();
            if (xfer_req) begin
                chk_int("b2b_rdy_busy", int'(src_ready), 0);
                chk_int("b2b_hold", int'(xfer_data), dones + 1);
            end
            if (xfer_data != prev) begin
                acc++;
                if (acc > 1) chk_int("b2b_order", int'(prev_done), 1);
            end
            prev = xfer_data;
            prev_done = done;
            if (done) begin
                dones++;
                model_cnt = (model_cnt + 1) % 4;
                if (dones < 3) src_data = 8'(dones + 1);
                else src_valid = 1'b0;
            end
            ack = a2; a2 = a1; a1 = xfer_req;
        end
        ack = 1'b0;
        src_valid = 1'b0;
        chk_int("b2b_dones", dones, 3);
        chk_int("b2b_accepts", acc, 3);
        chk_int("b2b_cnt", int'(xfer_cnt), model_cnt);

        // Stale ack blocks acceptance until it drops.
        step();
        ack = 1'b1; src_valid = 1'b1; src_data = 8'h77;
        #1;
        chk_int("stale_rdy", int'(src_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stale_hold", act, pk(0, 0, 0, 0, 2'(model_cnt), 8'h03));
        end
        ack = 1'b0;
        #1;
        chk_int("stale_rdy_drop", int'(src_ready), 1);
        step();
        src_valid = 1'b0;
        chk_int("stale_accept", int'(xfer_data), 8'h77);
        drain("stale_done");

        // Reset while in RELEASE: no done, everything cleared.
        src_valid = 1'b1; src_data = 8'hC3;
        step();
        src_valid = 1'b0;
        for (int i = 0; i < 20 && !xfer_req; i++) step();
        chk_int("rst_req_up", int'(xfer_req), 1);
        ack = 1'b1;
        for (int i = 0; i < 20 && xfer_req; i++) step();
        chk_int("rst_req_down", int'(xfer_req), 0);
        rstn = 1'b0;
        ack = 1'b0;
        step();
        chk("rst_mid", act, pk(0, 0, 0, 0, 2'd0, 8'h00));
        rstn = 1'b1;
        model_cnt = 0;
        run_xfer(8'h5E, 2, 2, se);
        chk_int("rst_after_err", int'(se), 0);
        chk_int("rst_after_cnt", int'(xfer_cnt), 1);

        // Counter wrap over five transfers.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run_xfer(8'(i * 16 + 1), 1, 2, se);
            chk_int("wrap_err", int'(se), 0);
            chk_int("wrap_cnt", int'(xfer_cnt), int'(wrap_exp[i]));
        end

        // Randomized transfers with random destination latencies and idle gaps.
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step();
                chk("rand_idle", act, pk(1, 0, 0, 0, 2'(model_cnt), last_data));
            end
            run_xfer(8'($urandom), int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), se);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
